encoder_16_to_4: RTL and testbench

Priority encoder that converts the 16-bit one-hot instruction-family vector from the decode logic into a 4-bit family number. The state machine uses the number as the microcode dispatch target (`{number, 3'b000}`). The block has two output paths:
- A combinational path, which the state machine's next-address logic consumes in the same cycle.
- A registered status path, which records the last encode result and sticky encoding errors for debug.

---
 rtl/encoder_pkg.sv | 17 +
 rtl/encoder_16_to_4_priority_enc_4to2.sv | 23 ++
 rtl/encoder_16_to_4.sv | 70 +++++++
 tb/tb_encoder_16_to_4.sv | 128 ++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared widths, family number type and group helper for the family encoder
package encoder_pkg;

    localparam int FAMILY_W     = 16;
    localparam int FAMILY_NUM_W = 4;
    localparam int GROUP_W      = 4;
    localparam int GROUPS       = FAMILY_W / GROUP_W;

    typedef logic [FAMILY_NUM_W-1:0] family_num_t;

    // True when at least two of the four bits are set.
    function automatic logic two_or_more4(input logic [3:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[0] & v[3]) |
               (v[1] & v[2]) | (v[1] & v[3]) | (v[2] & v[3]);
    endfunction

endpackage

// File: rtl/encoder_16_to_4_priority_enc_4to2.sv
// rtl/encoder_16_to_4_priority_enc_4to2.sv - 4-input lowest-index priority encoder
module priority_enc_4to2
    import encoder_pkg::*;
(
    input  logic [3:0] in_bits,
    output logic [1:0] idx,
    output logic       any
);

    // Index falls back to 0 with no bit set so the parent's zero case needs no extra mux.
    always_comb begin
        idx = 2'd0;
        any = |in_bits;
        casez (in_bits)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/encoder_16_to_4.sv
// rtl/encoder_16_to_4.sv - 16-to-4 instruction-family priority encoder with registered debug status
module encoder_16_to_4
    import encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bits,
    output logic [3:0]  number,
    output logic        valid,
    output logic        multi_hot,
    output logic [3:0]  number_q,
    output logic        valid_q,
    output logic        err_sticky
);

    logic [GROUPS-1:0] group_any;
    logic [1:0]        group_idx [GROUPS];
    logic [1:0]        sel_idx;
    logic              any_set;

    family_num_t number_d;
    logic        valid_d;
    logic        err_sticky_d;
    logic        err_sticky_q;

    for (genvar g = 0; g < GROUPS; g++) begin : g_group
        priority_enc_4to2 u_group (
            .in_bits (bits[GROUP_W*g +: GROUP_W]),
            .idx     (group_idx[g]),
            .any     (group_any[g])
        );
    end

    // Second level picks the lowest populated group; its local index fills the low bits.
    priority_enc_4to2 u_select (
        .in_bits (group_any),
        .idx     (sel_idx),
        .any     (any_set)
    );

    always_comb begin
        number    = {sel_idx, group_idx[sel_idx]};
        valid     = any_set;
        multi_hot = two_or_more4(group_any);
        for (int g = 0; g < GROUPS; g++) begin
            multi_hot = multi_hot | two_or_more4(bits[GROUP_W*g +: GROUP_W]);
        end
    end

    always_comb begin
        number_d     = number;
        valid_d      = valid;
        err_sticky_d = err_sticky_q | ~valid | multi_hot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            number_q     <= '0;
            valid_q      <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            number_q     <= number_d;
            valid_q      <= valid_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_encoder_16_to_4.sv
// tb/tb_encoder_16_to_4.sv - self-checking bench for encoder_16_to_4
module tb_encoder_16_to_4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bits;
    logic [3:0]  number;
    logic        valid;
    logic        multi_hot;
    logic [3:0]  number_q;
    logic        valid_q;
    logic        err_sticky;

    int n_assert = 0;
    int n_fail   = 0;

    int m_number_q   = 0;
    int m_valid_q    = 0;
    int m_err_sticky = 0;

    encoder_16_to_4 dut (
        .clk        (clk),
        .reset      (reset),
        .bits       (bits),
        .number     (number),
        .valid      (valid),
        .multi_hot  (multi_hot),
        .number_q   (number_q),
        .valid_q    (valid_q),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    function automatic int ref_number(input logic [15:0] v);
        int r = 0;
        for (int i = 15; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: check combinational outputs, clock, then check registered outputs.
    task automatic drive(input logic [15:0] v, input logic rst);
        int pop;
        reset = rst;
        bits  = v;
        #1;
        pop = $countones(v);
        check("number", {28'd0, number}, ref_number(v));
        check("valid", {31'd0, valid}, (v != 16'd0) ? 1 : 0);
        check("multi_hot", {31'd0, multi_hot}, (pop >= 2) ? 1 : 0);
        if (rst) begin
            m_number_q   = 0;
            m_valid_q    = 0;
            m_err_sticky = 0;
        end else begin
            m_number_q = ref_number(v);
            m_valid_q  = (v != 16'd0) ? 1 : 0;
            if (v == 16'd0 || pop >= 2) m_err_sticky = 1;
        end
        @(posedge clk);
        #1;
        check("number_q", {28'd0, number_q}, m_number_q);
        check("valid_q", {31'd0, valid_q}, m_valid_q);
        check("err_sticky", {31'd0, err_sticky}, m_err_sticky);
    endtask

    initial begin
        reset = 1'b1;
        bits  = 16'h0000;

        drive(16'h0000, 1'b1);
        drive(16'h8010, 1'b1);
        check("reset_number_q", {28'd0, number_q}, 0);
        check("reset_err", {31'd0, err_sticky}, 0);

        for (int k = 0; k < 16; k++) begin
            drive(16'h0001 << k, 1'b0);
            check("sweep_number", {28'd0, number}, k);
            check("sweep_number_q", {28'd0, number_q}, k);
            check("sweep_err", {31'd0, err_sticky}, 0);
        end

        drive(16'h0000, 1'b0);
        check("zero_number", {28'd0, number}, 0);
        check("zero_valid", {31'd0, valid}, 0);
        check("zero_err", {31'd0, err_sticky}, 1);

        drive(16'h8010, 1'b0);
        check("mh_8010_number", {28'd0, number}, 4);
        check("mh_8010_flag", {31'd0, multi_hot}, 1);
        drive(16'hFFFF, 1'b0);
        check("mh_ffff_number", {28'd0, number}, 0);
        drive(16'h0006, 1'b0);
        check("mh_0006_number", {28'd0, number}, 1);

        drive(16'h0000, 1'b1);
        check("rst_valid_q", {31'd0, valid_q}, 0);
        check("rst_err", {31'd0, err_sticky}, 0);
        drive(16'h0020, 1'b0);
        check("post_rst_number_q", {28'd0, number_q}, 5);
        check("post_rst_valid_q", {31'd0, valid_q}, 1);
        check("post_rst_err", {31'd0, err_sticky}, 0);

        drive(16'h0003, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(16'h0001 << (i % 16), 1'b0);
            check("sticky_hold", {31'd0, err_sticky}, 1);
        end
        drive(16'h0004, 1'b1);
        check("sticky_clear", {31'd0, err_sticky}, 0);

        for (int i = 0; i < 10000; i++) begin
            drive(16'($urandom), ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
